// File: rtl/id_issue_scoreboard_pkg.sv
// Shared constants and the write-port request payload for the decode issue controller.
package id_issue_scoreboard_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned XLEN       = 32;

   localparam logic [0:0] ARB_NORMAL = 1'b0;
   localparam logic [0:0] ARB_DRAIN  = 1'b1;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wr_req_t;

endpackage

// File: rtl/id_issue_scoreboard_wb_port_arbiter.sv
// Register-file write-port arbiter: pipe writeback first, long unit otherwise,
// with a starvation FSM that asks decode to bubble when the long unit waits too long.
module id_issue_scoreboard_wb_port_arbiter
   import id_issue_scoreboard_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned CNT_W        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  wr_req_t               wb_req,
   input  wr_req_t               lu_req,
   output logic                  lu_ready_c,
   output logic                  drain_c,
   output logic                  cap_valid_c,
   output logic [REG_ADDR_W-1:0] cap_addr_c,
   output logic                  reg_file_wr_en,
   output logic [REG_ADDR_W-1:0] reg_file_wr_addr,
   output logic [XLEN-1:0]       reg_file_wr_data
);

   logic [0:0]       state, state_n;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
   wr_req_t          sel;

   // Grant and the write that will be captured at the next edge
   always_comb begin
      lu_ready_c  = lu_req.valid & ~wb_req.valid;
      sel         = wb_req.valid ? wb_req : lu_req;
      cap_valid_c = wb_req.valid | lu_ready_c;
      cap_addr_c  = sel.addr;
      drain_c     = (state == ARB_DRAIN);
   end

   always_comb begin
      state_n      = state;
      starve_cnt_n = starve_cnt;
      case (state)
         ARB_NORMAL: begin
            if (lu_ready_c) begin
               starve_cnt_n = '0;
            end else if (lu_req.valid) begin
               if (starve_cnt != CNT_W'(STARVE_LIMIT))
                  starve_cnt_n = starve_cnt + CNT_W'(1);
               if (starve_cnt_n == CNT_W'(STARVE_LIMIT))
                  state_n = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            // Either the long unit got its slot or it gave up; start a fresh episode
            if (lu_ready_c || !lu_req.valid) begin
               state_n      = ARB_NORMAL;
               starve_cnt_n = '0;
            end
         end
         default: begin
            state_n      = ARB_NORMAL;
            starve_cnt_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_NORMAL;
         starve_cnt <= '0;
      end else begin
         state      <= state_n;
         starve_cnt <= starve_cnt_n;
      end
   end

   // Registered write port, one cycle behind the request
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_file_wr_en   <= 1'b0;
         reg_file_wr_addr <= '0;
         reg_file_wr_data <= '0;
      end else begin
         reg_file_wr_en <= cap_valid_c;
         if (cap_valid_c) begin
            reg_file_wr_addr <= sel.addr;
            reg_file_wr_data <= sel.data;
         end
      end
   end

endmodule

// File: rtl/id_issue_scoreboard.sv
// Decode issue controller: pending-write scoreboard for RAW/WAW stalls plus
// arbitration of the single register-file write port.
module id_issue_scoreboard
   import id_issue_scoreboard_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned MAX_LONG     = 4,
   parameter int unsigned CNT_W        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic                  id_flush,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  id_wb_reg_file,
   input  logic                  id_long,
   output logic                  id_stall,
   output logic                  id_issue,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  lu_valid,
   input  logic [REG_ADDR_W-1:0] lu_addr,
   input  logic [XLEN-1:0]       lu_data,
   output logic                  lu_ready,
   output logic                  reg_file_wr_en,
   output logic [REG_ADDR_W-1:0] reg_file_wr_addr,
   output logic [XLEN-1:0]       reg_file_wr_data
);

   logic [NUM_REGS-1:0]   pending, pending_n;
   logic [CNT_W-1:0]      long_cnt, long_cnt_n;
   logic                  hazard;
   logic                  drain_c, cap_valid_c;
   logic [REG_ADDR_W-1:0] cap_addr_c;
   wr_req_t               wb_req, lu_req;

   always_comb begin
      wb_req = '{valid: wb_valid, addr: wb_addr, data: wb_data};
      lu_req = '{valid: lu_valid, addr: lu_addr, data: lu_data};
   end

   id_issue_scoreboard_wb_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_arb (
      .clk              (clk),
      .rst              (rst),
      .wb_req           (wb_req),
      .lu_req           (lu_req),
      .lu_ready_c       (lu_ready),
      .drain_c          (drain_c),
      .cap_valid_c      (cap_valid_c),
      .cap_addr_c       (cap_addr_c),
      .reg_file_wr_en   (reg_file_wr_en),
      .reg_file_wr_addr (reg_file_wr_addr),
      .reg_file_wr_data (reg_file_wr_data)
   );

   // Hazard detection and issue decision
   always_comb begin
      hazard = (id_use_rs1 & pending[id_rs1])
             | (id_use_rs2 & pending[id_rs2])
             | (id_wb_reg_file & pending[id_rd])
             | (id_long & (long_cnt == CNT_W'(MAX_LONG)));
      id_stall = id_valid & ~id_flush & (hazard | drain_c);
      id_issue = id_valid & ~id_flush & ~id_stall;
   end

   // Release on captured write, then claim on issue so a same-cycle set wins
   always_comb begin
      pending_n = pending;
      if (cap_valid_c)
         pending_n[cap_addr_c] = 1'b0;
      if (id_issue && id_wb_reg_file && (id_rd != '0))
         pending_n[id_rd] = 1'b1;
      pending_n[0] = 1'b0;

      long_cnt_n = long_cnt;
      case ({id_issue & id_long, lu_ready})
         2'b10:   long_cnt_n = long_cnt + CNT_W'(1);
         2'b01:   if (long_cnt != '0) long_cnt_n = long_cnt - CNT_W'(1);
         default: long_cnt_n = long_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         long_cnt <= '0;
      end else begin
         pending  <= pending_n;
         long_cnt <= long_cnt_n;
      end
   end

   a_lu_has_owner: assert property (@(posedge clk) disable iff (rst)
      lu_valid |-> (long_cnt != '0))
      else $error("long-unit return with no outstanding long op");

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed table-driven bench for id_issue_scoreboard with hand-built drain and reset sequences.
module tb_id_issue_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_flush, id_use_rs1, id_use_rs2, id_wb_reg_file, id_long;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_stall, id_issue;
   logic        wb_valid, lu_valid, lu_ready;
   logic [4:0]  wb_addr, lu_addr;
   logic [31:0] wb_data, lu_data;
   logic        reg_file_wr_en;
   logic [4:0]  reg_file_wr_addr;
   logic [31:0] reg_file_wr_data;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // Data tags the source so a swapped mux is visible on the port
   assign wb_data = 32'hB000_0000 | 32'(wb_addr);
   assign lu_data = 32'hC000_0000 | 32'(lu_addr);

   id_issue_scoreboard dut (
      .clk              (clk),
      .rst              (rst),
      .id_valid         (id_valid),
      .id_flush         (id_flush),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .id_rd            (id_rd),
      .id_use_rs1       (id_use_rs1),
      .id_use_rs2       (id_use_rs2),
      .id_wb_reg_file   (id_wb_reg_file),
      .id_long          (id_long),
      .id_stall         (id_stall),
      .id_issue         (id_issue),
      .wb_valid         (wb_valid),
      .wb_addr          (wb_addr),
      .wb_data          (wb_data),
      .lu_valid         (lu_valid),
      .lu_addr          (lu_addr),
      .lu_data          (lu_data),
      .lu_ready         (lu_ready),
      .reg_file_wr_en   (reg_file_wr_en),
      .reg_file_wr_addr (reg_file_wr_addr),
      .reg_file_wr_data (reg_file_wr_data)
   );

   typedef struct {
      logic       vld, fl;
      logic [4:0] rs1; logic u1;
      logic [4:0] rs2; logic u2;
      logic [4:0] rd;  logic wbrf, lng;
      logic       wbv; logic [4:0] wba;
      logic       luv; logic [4:0] lua;
      logic       e_stall, e_issue, e_lur, e_wen;
      logic [4:0] e_wa; logic e_wlu;
   } vec_t;

   // Argument order: id fields, wb/lu requests, then expected outputs
   function automatic vec_t mk(
      input logic vld, fl, input logic [4:0] rs1, input logic u1,
      input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic wbrf, lng,
      input logic wbv, input logic [4:0] wba, input logic luv, input logic [4:0] lua,
      input logic e_stall, e_issue, e_lur, e_wen, input logic [4:0] e_wa, input logic e_wlu);
      vec_t v;
      v.vld = vld; v.fl = fl; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.rd = rd; v.wbrf = wbrf; v.lng = lng; v.wbv = wbv; v.wba = wba;
      v.luv = luv; v.lua = lua; v.e_stall = e_stall; v.e_issue = e_issue;
      v.e_lur = e_lur; v.e_wen = e_wen; v.e_wa = e_wa; v.e_wlu = e_wlu;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, check mid-cycle, then advance past the edge
   task automatic run_row(input vec_t v, input string tag);
      logic [31:0] e_data;
      id_valid = v.vld; id_flush = v.fl; id_rs1 = v.rs1; id_use_rs1 = v.u1;
      id_rs2 = v.rs2; id_use_rs2 = v.u2; id_rd = v.rd; id_wb_reg_file = v.wbrf;
      id_long = v.lng; wb_valid = v.wbv; wb_addr = v.wba; lu_valid = v.luv; lu_addr = v.lua;
      #3;
      chk({tag, " id_stall"}, 32'(id_stall), 32'(v.e_stall));
      chk({tag, " id_issue"}, 32'(id_issue), 32'(v.e_issue));
      chk({tag, " lu_ready"}, 32'(lu_ready), 32'(v.e_lur));
      chk({tag, " wr_en"}, 32'(reg_file_wr_en), 32'(v.e_wen));
      if (v.e_wen) begin
         e_data = (v.e_wlu ? 32'hC000_0000 : 32'hB000_0000) | 32'(v.e_wa);
         chk({tag, " wr_addr"}, 32'(reg_file_wr_addr), 32'(v.e_wa));
         chk({tag, " wr_data"}, reg_file_wr_data, e_data);
      end
      step();
   endtask

   vec_t tbl[30];

   initial begin
      // Long-op RAW until lu return, then arbitration priority
      tbl[0]  = mk(1,0, 0,0, 0,0, 5,1,1, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[1]  = mk(1,0, 5,1, 0,0, 0,0,0, 0,0, 0,0, 1,0,0,0, 0,0);
      tbl[2]  = mk(1,0, 5,1, 0,0, 0,0,0, 0,0, 0,0, 1,0,0,0, 0,0);
      tbl[3]  = mk(1,0, 5,1, 0,0, 0,0,0, 0,0, 1,5, 1,0,1,0, 0,0);
      tbl[4]  = mk(1,0, 5,1, 0,0, 0,0,0, 0,0, 0,0, 0,1,0,1, 5,1);
      tbl[5]  = mk(1,0, 0,0, 0,0, 7,1,1, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[6]  = mk(0,0, 0,0, 0,0, 0,0,0, 1,3, 1,7, 0,0,0,0, 0,0);
      tbl[7]  = mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 1,7, 0,0,1,1, 3,0);
      tbl[8]  = mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,0,1, 7,1);
      tbl[9]  = mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0);
      // Outstanding long-op limit
      tbl[10] = mk(1,0, 0,0, 0,0, 1,1,1, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[11] = mk(1,0, 0,0, 0,0, 2,1,1, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[12] = mk(1,0, 0,0, 0,0, 3,1,1, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[13] = mk(1,0, 0,0, 0,0, 4,1,1, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[14] = mk(1,0, 0,0, 0,0, 5,1,1, 0,0, 0,0, 1,0,0,0, 0,0);
      tbl[15] = mk(1,0, 7,1, 0,0, 6,1,0, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[16] = mk(1,0, 0,0, 0,0, 5,1,1, 0,0, 1,1, 1,0,1,0, 0,0);
      tbl[17] = mk(1,0, 0,0, 0,0, 5,1,1, 0,0, 0,0, 0,1,0,1, 1,1);
      // rs2 RAW against pipe writer, WAW
      tbl[18] = mk(1,0, 0,0, 6,1, 0,0,0, 1,6, 0,0, 1,0,0,0, 0,0);
      tbl[19] = mk(1,0, 0,0, 6,1, 0,0,0, 0,0, 0,0, 0,1,0,1, 6,0);
      tbl[20] = mk(1,0, 0,0, 0,0, 3,1,0, 0,0, 0,0, 1,0,0,0, 0,0);
      // x0 never pending, flush semantics
      tbl[21] = mk(1,0, 0,0, 0,0, 0,1,0, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[22] = mk(1,0, 0,1, 0,1, 0,0,0, 1,0, 0,0, 0,1,0,0, 0,0);
      tbl[23] = mk(1,1, 2,1, 0,0, 9,1,0, 0,0, 0,0, 0,0,0,1, 0,0);
      tbl[24] = mk(1,0, 9,1, 0,0, 0,0,0, 0,0, 0,0, 0,1,0,0, 0,0);
      tbl[25] = mk(1,0, 2,1, 0,0, 0,0,0, 0,0, 0,0, 1,0,0,0, 0,0);
      // Same-cycle set and clear: set wins
      tbl[26] = mk(1,0, 0,0, 0,0, 8,1,0, 1,8, 0,0, 0,1,0,0, 0,0);
      tbl[27] = mk(1,0, 8,1, 0,0, 0,0,0, 0,0, 0,0, 1,0,0,1, 8,0);
      tbl[28] = mk(1,0, 8,1, 0,0, 0,0,0, 1,8, 0,0, 1,0,0,0, 0,0);
      tbl[29] = mk(1,0, 8,1, 0,0, 0,0,0, 0,0, 0,0, 0,1,0,1, 8,0);

      rst = 1'b1;
      id_valid = 0; id_flush = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_wb_reg_file = 0; id_long = 0;
      wb_valid = 0; wb_addr = 0; lu_valid = 0; lu_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      chk("reset wr_addr", 32'(reg_file_wr_addr), 32'd0);
      chk("reset wr_data", reg_file_wr_data, 32'd0);
      run_row(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0), "reset idle");

      for (int i = 0; i < 30; i++) run_row(tbl[i], $sformatf("vec%0d", i));

      // Starvation: 8 waiting cycles then drain; long_cnt is 4 here
      for (int k = 0; k < 8; k++)
         run_row(mk(1,0, 11,1, 0,0, 0,0,0, 1,10, 1,2, 0,1,0, (k != 0), 10,0),
                 $sformatf("starve%0d", k));
      for (int k = 0; k < 2; k++)
         run_row(mk(1,0, 11,1, 0,0, 0,0,0, 1,10, 1,2, 1,0,0,1, 10,0),
                 $sformatf("drain%0d", k));
      run_row(mk(1,0, 11,1, 0,0, 0,0,0, 0,0, 1,2, 1,0,1,1, 10,0), "drain grant");
      run_row(mk(1,0, 11,1, 0,0, 0,0,0, 0,0, 0,0, 0,1,0,1, 2,1), "drain exit");
      // Counter was cleared: a full 8 cycles pass again before draining
      for (int k = 0; k < 8; k++)
         run_row(mk(1,0, 11,1, 0,0, 0,0,0, 1,10, 1,3, 0,1,0, (k != 0), 10,0),
                 $sformatf("restarve%0d", k));
      run_row(mk(1,0, 11,1, 0,0, 0,0,0, 1,10, 1,3, 1,0,0,1, 10,0), "redrain");
      run_row(mk(1,0, 11,1, 0,0, 0,0,0, 0,0, 0,0, 1,0,0,1, 10,0), "lu drop");
      run_row(mk(1,0, 11,1, 0,0, 0,0,0, 0,0, 0,0, 0,1,0,0, 0,0), "drop exit");

      // Mid-operation reset with pending {4,5,12} and long_cnt 2
      run_row(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 1,3, 0,0,1,0, 0,0), "pre-rst lu");
      run_row(mk(1,0, 0,0, 0,0, 12,1,0, 0,0, 0,0, 0,1,0,1, 3,1), "pre-rst issue");
      run_row(mk(1,0, 4,1, 0,0, 0,0,0, 0,0, 0,0, 1,0,0,0, 0,0), "pre-rst raw");
      rst = 1'b1;
      run_row(mk(1,0, 0,0, 0,0, 14,1,0, 1,13, 0,0, 0,1,0,0, 0,0), "rst cycle");
      rst = 1'b0;
      #3;
      chk("post-rst wr_addr", 32'(reg_file_wr_addr), 32'd0);
      chk("post-rst wr_data", reg_file_wr_data, 32'd0);
      run_row(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0), "post-rst idle");
      run_row(mk(1,0, 4,1, 12,1, 5,1,0, 0,0, 0,0, 0,1,0,0, 0,0), "post-rst free");
      for (int k = 0; k < 4; k++)
         run_row(mk(1,0, 0,0, 0,0, 5'(20 + k),1,1, 0,0, 0,0, 0,1,0,0, 0,0),
                 $sformatf("post-rst long%0d", k));
      run_row(mk(1,0, 0,0, 0,0, 24,1,1, 0,0, 0,0, 1,0,0,0, 0,0), "post-rst long full");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/id_issue_scoreboard.md
Name: id_issue_scoreboard

Overview:
- Issue controller for the decode stage. A 32-entry pending-write scoreboard stalls decode on RAW/WAW hazards against in-flight writers.
- Arbitrates the single register-file write port between the in-order pipeline writeback and a long-latency unit (loads/mul/div return), with a starvation guard.
- Sits between decode and the register file write port. Drives reg_file_wr_en/addr/data and the decode stall.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles the long unit may wait before decode is forced to bubble.
- MAX_LONG, 4: maximum outstanding long-latency ops.
- CNT_W, 4: width of the starvation and outstanding counters; must hold max(STARVE_LIMIT, MAX_LONG).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds an instruction
- id_flush  in  1  decode instruction squashed this cycle
- id_rs1, id_rs2, id_rd  in  5 each  decoded register addresses
- id_use_rs1, id_use_rs2  in  1 each  operand actually read
- id_wb_reg_file  in  1  instruction writes rd
- id_long  in  1  result returns via long-latency unit
- id_stall  out  1  hold fetch/decode this cycle
- id_issue  out  1  instruction leaves decode this cycle
- wb_valid, wb_addr[4:0], wb_data[31:0]  in  pipeline writeback request, never stallable
- lu_valid, lu_addr[4:0], lu_data[31:0]  in  long-unit writeback request
- lu_ready  out  1  long-unit request accepted this cycle
- reg_file_wr_en  out  1, reg_file_wr_addr  out  5, reg_file_wr_data  out  32  registered write port

Behaviour:
- Reset (sync, rst=1 at posedge):
  - pending = 0, long_cnt = 0, starve_cnt = 0, state = ARB_NORMAL.
  - reg_file_wr_en = 0, addr = 0, data = 0.
  - Comb outputs with idle inputs: id_stall = 0, id_issue = 0, lu_ready = 0.
  - Reset mid-operation discards all pending bits and outstanding counts.
- hazard (comb) is true if any of:
  - id_use_rs1 and pending[id_rs1], or id_use_rs2 and pending[id_rs2];
  - id_wb_reg_file and pending[id_rd];
  - id_long and long_cnt == MAX_LONG.
  - Register x0 is never pending.
- id_stall = id_valid & !id_flush & (hazard | state == ARB_DRAIN).
- id_issue = id_valid & !id_flush & !id_stall.
- Write-port grant (comb):
  - Pipe has priority; lu_ready = lu_valid & !wb_valid.
  - The selected request (wb, else lu when lu_ready) is captured into reg_file_wr_* at the next posedge, giving 1-cycle latency.
  - Writes with addr 0 still pass to the port; the register file ignores x0.
- Scoreboard, at posedge:
  - Clear pending[a] when a write to a is captured into the port register. Decode therefore sees the release one cycle after the request, coincident with reg_file_wr_en.
  - Set pending[id_rd] on id_issue & id_wb_reg_file & id_rd != 0.
  - Set and clear of the same index in one cycle: set wins.
- long_cnt: +1 on id_issue & id_long; -1 on lu_ready; both in one cycle leaves it unchanged. It never exceeds MAX_LONG and never underflows (lu_valid with long_cnt = 0 is an upstream error, flagged by a simulation assertion).
- Arbiter FSM:
  - ARB_NORMAL:
    - If lu_valid & !lu_ready, starve_cnt increments, saturating at STARVE_LIMIT.
    - If lu_ready, starve_cnt = 0.
    - When starve_cnt reaches STARVE_LIMIT with lu still waiting, go to ARB_DRAIN.
  - ARB_DRAIN:
    - id_stall is forced so that bubbles reach WB.
    - On lu_ready, go to ARB_NORMAL with starve_cnt = 0.
    - If lu_valid drops, go to ARB_NORMAL.
- id_flush suppresses issue only. It never clears pending bits; squashed instructions never set them.

Decomposition:
- Shared defines (same package as the opcodes):
  - ARB_NORMAL = 1'b0, ARB_DRAIN = 1'b1;
  - REG_ADDR_W = 5, NUM_REGS = 32, XLEN = 32.
- One natural sub-module: wb_port_arbiter (grant logic, starvation FSM, registered write port). It exports a captured-write valid/addr pair to the scoreboard.

Test Plan:
1. Reset, then issue id_rd=5 with id_long=1; next cycle id_rs1=5 with use_rs1 → id_stall=1 every cycle until lu_valid/lu_addr=5 is accepted. reg_file_wr_en=1/addr=5 the next cycle, and id_issue=1 that same cycle.
2. Same-cycle wb_valid addr=3 and lu_valid addr=7 → lu_ready=0, port writes 3. Next cycle with wb idle → lu_ready=1, port writes 7 one cycle later.
3. wb_valid held high 8 cycles with lu_valid waiting → state ARB_DRAIN, id_stall=1 with a hazard-free instruction. Once wb_valid drops, lu granted, state returns to ARB_NORMAL and starve_cnt=0.
4. Issue 4 long ops to rd=1..4 → the 5th long op stalls (long_cnt=4), while a non-long op with free registers issues. One lu return releases the stall next cycle.
5. Issue rd=0 with wb_reg_file → pending stays 0, and a following rs1=0 reader never stalls. id_flush=1 with a hazard → id_stall=0, id_issue=0, pending unchanged.
6. Assert rst for one cycle with 3 pending bits and long_cnt=2 → all cleared, write port disabled the following cycle.
